// File: rtl/clkgen_seq.sv
// Clock-tree bring-up sequencer: orders DCM/PLL reset release, watches lock
// signals, gates downstream domain resets and retries or latches FAIL.
module clkgen_seq #(
    parameter int RST_PULSE_CYC = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYC    = 16,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       dcm0_locked_i,
    input  logic       dcm1_locked_i,
    input  logic       pll0_locked_i,
    input  logic       restart_i,
    input  logic       clr_i,
    output logic       dcm_rst_o,
    output logic       pll_rst_o,
    output logic       domains_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic       lock_lost_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_RESET_DCM = 3'd0,
        S_WAIT_DCM  = 3'd1,
        S_WAIT_PLL  = 3'd2,
        S_SETTLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       retry_n;
    logic             lost_n;
    logic             fail_attempt;

    // Lock bits ordered {pll0, dcm1, dcm0}; two flops per bit against metastability.
    logic [2:0] lock_meta, lock_sync;
    logic       dcm_ok, all_ok;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            lock_meta <= '0;
            lock_sync <= '0;
        end else begin
            lock_meta <= {pll0_locked_i, dcm1_locked_i, dcm0_locked_i};
            lock_sync <= lock_meta;
        end
    end

    assign dcm_ok  = lock_sync[0] & lock_sync[1];
    assign all_ok  = &lock_sync;
    assign state_o = state;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_n      = state;
        retry_n      = retry_cnt_o;
        lost_n       = lock_lost_o;
        fail_attempt = 1'b0;

        if (clr_i) lost_n = 1'b0;

        if (restart_i) begin
            state_n = S_RESET_DCM;
            retry_n = '0;
        end else begin
            unique case (state)
                S_RESET_DCM: if (cnt == PULSE_LAST) state_n = S_WAIT_DCM;
                S_WAIT_DCM: begin
                    if (dcm_ok)                     state_n      = S_WAIT_PLL;
                    else if (cnt == TIMEOUT_LAST)   fail_attempt = 1'b1;
                end
                S_WAIT_PLL: begin
                    if (!dcm_ok)                    fail_attempt = 1'b1;
                    else if (lock_sync[2])          state_n      = S_SETTLE;
                    else if (cnt == TIMEOUT_LAST)   fail_attempt = 1'b1;
                end
                S_SETTLE: begin
                    if (!all_ok)                    fail_attempt = 1'b1;
                    else if (cnt == SETTLE_LAST)    state_n      = S_RUN;
                end
                S_RUN: begin
                    // A loss after a good bring-up is not a failed attempt.
                    if (!all_ok) begin
                        lost_n  = 1'b1;
                        state_n = S_RESET_DCM;
                    end
                end
                S_FAIL:  state_n = S_FAIL;
                default: state_n = S_RESET_DCM;
            endcase

            if (fail_attempt) begin
                if (retry_cnt_o != RETRY_MAX) retry_n = retry_cnt_o + 2'd1;
                state_n = (retry_n == RETRY_MAX) ? S_FAIL : S_RESET_DCM;
            end
            if (state_n == S_RUN) retry_n = '0;
        end

        // Counter restarts on every state entry, including a restart into RESET_DCM.
        cnt_n = (state_n != state || restart_i) ? '0 : cnt + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state         <= S_RESET_DCM;
            cnt           <= '0;
            retry_cnt_o   <= '0;
            lock_lost_o   <= 1'b0;
            dcm_rst_o     <= 1'b1;
            pll_rst_o     <= 1'b1;
            domains_rst_o <= 1'b1;
            ready_o       <= 1'b0;
            fail_o        <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            retry_cnt_o   <= retry_n;
            lock_lost_o   <= lost_n;
            dcm_rst_o     <= (state_n == S_RESET_DCM) || (state_n == S_FAIL);
            pll_rst_o     <= (state_n == S_RESET_DCM) || (state_n == S_WAIT_DCM) ||
                             (state_n == S_FAIL);
            domains_rst_o <= (state_n != S_RUN);
            ready_o       <= (state_n == S_RUN);
            fail_o        <= (state_n == S_FAIL);
        end
    end

endmodule
